// File: rtl/uart_rx_msg_ctrl.sv
// uart_rx_msg_ctrl: drives the UART receiver and packs MSG_BYTES received bytes into one message.
// Optional UART_MSG_CHECKSUM_EN: last byte must equal the XOR of the preceding bytes (error 100 otherwise).
module uart_rx_msg_ctrl #(
  parameter int MSG_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   ctrl_enable,
  input  logic [2:0]             cfg_baud_sel,
  input  logic                   Rx_VALID,
  input  logic [7:0]             Rx_DATA,
  input  logic                   Rx_PERROR,
  input  logic                   Rx_FERROR,
  output logic                   Rx_EN,
  output logic [2:0]             baud_select,
  output logic [8*MSG_BYTES-1:0] msg_data,
  output logic                   msg_valid,
  output logic                   msg_error,
  output logic [2:0]             err_code,
  output logic                   busy
);

  localparam int CW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(MSG_BYTES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_PARITY   = 3'b001;
  localparam logic [2:0] ERR_FRAME    = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b011;
  localparam logic [2:0] ERR_CHECKSUM = 3'b100;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} state_t;

  state_t                 state_reg;
  logic [CW-1:0]          count_reg;
  logic [TW-1:0]          timer_reg;
  logic [8*MSG_BYTES-1:0] buf_reg;
  logic [8*MSG_BYTES-1:0] buf_wr;
  logic [8*MSG_BYTES-1:0] msg_data_reg;
  logic                   msg_valid_reg;
  logic                   msg_error_reg;
  logic [2:0]             err_code_reg;
  logic [2:0]             baud_reg;
  logic                   busy_reg;
  logic                   rx_en_reg;
  logic                   valid_prev_reg;
  logic                   err_prev_reg;

  logic       valid_edge;
  logic       err_edge;
  logic [2:0] err_cause;
  logic       checksum_ok;

  assign valid_edge = Rx_VALID & ~valid_prev_reg;
  assign err_edge   = (Rx_PERROR | Rx_FERROR) & ~err_prev_reg;
  assign err_cause  = Rx_PERROR ? ERR_PARITY : ERR_FRAME;

  // Buffer with the incoming byte merged into the current slot; byte 0 sits in the MSBs.
  genvar gi;
  generate
    for (gi = 0; gi < MSG_BYTES; gi++) begin : g_slot
      assign buf_wr[8*(MSG_BYTES-1-gi) +: 8] =
        (count_reg == CW'(gi)) ? Rx_DATA : buf_reg[8*(MSG_BYTES-1-gi) +: 8];
    end
  endgenerate

`ifdef UART_MSG_CHECKSUM_EN
  logic [7:0] xor_acc;
  always_comb begin
    xor_acc = 8'h00;
    for (int i = 0; i < MSG_BYTES - 1; i++) begin
      xor_acc = xor_acc ^ buf_wr[8*(MSG_BYTES-1-i) +: 8];
    end
  end
  assign checksum_ok = (MSG_BYTES < 2) || (xor_acc == buf_wr[7:0]);
`else
  assign checksum_ok = 1'b1;
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      timer_reg      <= '0;
      buf_reg        <= '0;
      msg_data_reg   <= '0;
      msg_valid_reg  <= 1'b0;
      msg_error_reg  <= 1'b0;
      err_code_reg   <= ERR_NONE;
      baud_reg       <= 3'b000;
      busy_reg       <= 1'b0;
      rx_en_reg      <= 1'b0;
      valid_prev_reg <= 1'b0;
      err_prev_reg   <= 1'b0;
    end else begin
      valid_prev_reg <= Rx_VALID;
      err_prev_reg   <= Rx_PERROR | Rx_FERROR;
      msg_valid_reg  <= 1'b0;
      if (state_reg == IDLE) begin
        baud_reg <= cfg_baud_sel;
      end

      if (!ctrl_enable) begin
        // Disable abandons everything except the last good message.
        state_reg     <= IDLE;
        count_reg     <= '0;
        timer_reg     <= '0;
        busy_reg      <= 1'b0;
        rx_en_reg     <= 1'b0;
        msg_error_reg <= 1'b0;
        err_code_reg  <= ERR_NONE;
      end else begin
        case (state_reg)
          IDLE, COLLECT, DONE: begin
            if (err_edge) begin
              state_reg     <= ERROR;
              err_code_reg  <= err_cause;
              msg_error_reg <= 1'b1;
              count_reg     <= '0;
              timer_reg     <= '0;
              busy_reg      <= 1'b0;
              rx_en_reg     <= 1'b0;
            end else if (state_reg == DONE) begin
              state_reg <= IDLE;
              rx_en_reg <= 1'b1;
            end else if (valid_edge) begin
              buf_reg   <= buf_wr;
              timer_reg <= '0;
              if (count_reg == LAST_SLOT) begin
                count_reg <= '0;
                busy_reg  <= 1'b0;
                rx_en_reg <= 1'b0;
                if (checksum_ok) begin
                  state_reg     <= DONE;
                  msg_data_reg  <= buf_wr;
                  msg_valid_reg <= 1'b1;
                  msg_error_reg <= 1'b0;
                  err_code_reg  <= ERR_NONE;
                end else begin
                  state_reg     <= ERROR;
                  msg_error_reg <= 1'b1;
                  err_code_reg  <= ERR_CHECKSUM;
                end
              end else begin
                state_reg <= COLLECT;
                count_reg <= count_reg + CW'(1);
                busy_reg  <= 1'b1;
                rx_en_reg <= 1'b1;
              end
            end else if (state_reg == COLLECT) begin
              if (timer_reg == TIMER_MAX) begin
                state_reg     <= ERROR;
                err_code_reg  <= ERR_TIMEOUT;
                msg_error_reg <= 1'b1;
                count_reg     <= '0;
                timer_reg     <= '0;
                busy_reg      <= 1'b0;
                rx_en_reg     <= 1'b0;
              end else begin
                timer_reg <= timer_reg + TW'(1);
                rx_en_reg <= 1'b1;
              end
            end else begin
              rx_en_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            rx_en_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Rx_EN       = rx_en_reg;
  assign baud_select = baud_reg;
  assign msg_data    = msg_data_reg;
  assign msg_valid   = msg_valid_reg;
  assign msg_error   = msg_error_reg;
  assign err_code    = err_code_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_rx_msg_ctrl.sv
// Directed bench for uart_rx_msg_ctrl: message assembly, error classes, timeout, baud hold, disable, reset.
module tb_uart_rx_msg_ctrl;

  localparam int MSG_BYTES = 4;
  localparam int TIMEOUT   = 6000;
`ifdef UART_MSG_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        reset;
  logic        ctrl_enable;
  logic [2:0]  cfg_baud_sel;
  logic        Rx_VALID;
  logic [7:0]  Rx_DATA;
  logic        Rx_PERROR;
  logic        Rx_FERROR;
  logic        Rx_EN;
  logic [2:0]  baud_select;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_error;
  logic [2:0]  err_code;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  logic [31:0] exp_msg;
  logic [7:0]  lb;

  uart_rx_msg_ctrl #(.MSG_BYTES(MSG_BYTES), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clk(Clk), .reset(reset), .ctrl_enable(ctrl_enable), .cfg_baud_sel(cfg_baud_sel),
    .Rx_VALID(Rx_VALID), .Rx_DATA(Rx_DATA), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR),
    .Rx_EN(Rx_EN), .baud_select(baud_select), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_error(msg_error), .err_code(err_code), .busy(busy)
  );

  always #10 Clk = ~Clk;

  always @(negedge Clk) if (msg_valid) n_pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] last_of(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    return CK ? (a ^ b ^ c) : d;
  endfunction

  // Drives one byte from a falling edge; returns on the falling edge after `hold` rising edges.
  task automatic send_byte(input logic [7:0] b, input int hold, input logic pe, input logic fe);
    @(negedge Clk);
    Rx_DATA = b; Rx_VALID = 1'b1; Rx_PERROR = pe; Rx_FERROR = fe;
    repeat (hold) @(negedge Clk);
    Rx_VALID = 1'b0; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;
    $display("tx byte %02h hold=%0d pe=%0b fe=%0b -> busy=%0b err=%0b code=%03b",
             b, hold, pe, fe, busy, msg_error, err_code);
  endtask

  task automatic gap(input int cycles);
    repeat (cycles) @(negedge Clk);
  endtask

  initial begin
    reset = 1'b0; ctrl_enable = 1'b1; cfg_baud_sel = 3'b111;
    Rx_VALID = 1'b0; Rx_DATA = 8'h00; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;

    // 1: reset values, then enable and baud loaded
    #15;
    check("rst_rx_en", Rx_EN, 0);
    check("rst_baud", baud_select, 3'b000);
    #5 reset = 1'b1;
    @(negedge Clk);
    check("init_rx_en", Rx_EN, 1);
    check("init_baud", baud_select, 3'b111);
    check("init_data", msg_data, 0);
    check("init_valid", msg_valid, 0);
    check("init_error", msg_error, 0);
    check("init_code", err_code, 3'b000);
    check("init_busy", busy, 0);

    // 2: four bytes one frame apart
    lb = last_of(8'h8A, 8'h3C, 8'h55, 8'hF0);
    exp_msg = {8'h8A, 8'h3C, 8'h55, lb};
    n_pulses = 0;
    send_byte(8'h8A, 1, 0, 0);
    check("t2_busy", busy, 1);
    gap(4773);
    send_byte(8'h3C, 1, 0, 0); gap(4773);
    send_byte(8'h55, 1, 0, 0); gap(4773);
    check("t2_no_early_valid", n_pulses, 0);
    send_byte(lb, 1, 0, 0);
    check("t2_valid", msg_valid, 1);
    check("t2_data", msg_data, exp_msg);
    check("t2_busy_done", busy, 0);
    check("t2_rx_en_done", Rx_EN, 0);
    @(negedge Clk);
    check("t2_valid_drop", msg_valid, 0);
    check("t2_rx_en_idle", Rx_EN, 1);
    check("t2_pulses", n_pulses, 1);

    // 3: parity error on the third valid edge, then a good message
    send_byte(8'h11, 1, 0, 0); gap(10);
    send_byte(8'h22, 1, 0, 0); gap(10);
    send_byte(8'h33, 1, 1, 0);
    check("t3_error", msg_error, 1);
    check("t3_code", err_code, 3'b001);
    check("t3_data_kept", msg_data, exp_msg);
    check("t3_busy", busy, 0);
    check("t3_rx_en_err", Rx_EN, 0);
    @(negedge Clk);
    check("t3_sticky", msg_error, 1);
    lb = last_of(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    exp_msg = {8'hA1, 8'hB2, 8'hC3, lb};
    n_pulses = 0;
    send_byte(8'hA1, 1, 0, 0); gap(5);
    send_byte(8'hB2, 3, 0, 0); gap(5);
    send_byte(8'hC3, 1, 0, 0); gap(5);
    send_byte(lb, 1, 0, 0);
    check("t3_good_valid", msg_valid, 1);
    check("t3_good_data", msg_data, exp_msg);
    check("t3_error_clear", msg_error, 0);
    check("t3_code_clear", err_code, 3'b000);
    gap(3);
    check("t3_pulses", n_pulses, 1);

    // framing error, then parity+framing together (parity wins)
    send_byte(8'h44, 1, 0, 1);
    check("fe_code", err_code, 3'b010);
    check("fe_data_kept", msg_data, exp_msg);
    gap(3);
    send_byte(8'h45, 1, 1, 1);
    check("pe_fe_code", err_code, 3'b001);
    gap(3);

    // 4: inter-byte timeout
    send_byte(8'h5A, 1, 0, 0);
    gap(TIMEOUT - 1);
    check("t4_before_busy", busy, 1);
    check("t4_before_code", err_code, 3'b001);
    @(negedge Clk);
    check("t4_error", msg_error, 1);
    check("t4_code", err_code, 3'b011);
    check("t4_rx_en", Rx_EN, 0);
    check("t4_busy", busy, 0);
    @(negedge Clk);
    check("t4_rx_en_back", Rx_EN, 1);

    // 5: baud change mid-message is deferred to IDLE
    lb = last_of(8'h01, 8'h02, 8'h03, 8'h04);
    exp_msg = {8'h01, 8'h02, 8'h03, lb};
    send_byte(8'h01, 1, 0, 0);
    cfg_baud_sel = 3'b010;
    gap(5);
    check("t5_baud_hold", baud_select, 3'b111);
    send_byte(8'h02, 1, 0, 0); gap(5);
    send_byte(8'h03, 1, 0, 0); gap(5);
    send_byte(lb, 1, 0, 0);
    check("t5_data", msg_data, exp_msg);
    check("t5_baud_done", baud_select, 3'b111);
    @(negedge Clk);
    @(negedge Clk);
    check("t5_baud_idle", baud_select, 3'b010);

    // 6: disable after two bytes, then a fresh message
    n_pulses = 0;
    send_byte(8'h77, 1, 0, 0); gap(3);
    send_byte(8'h88, 1, 0, 0); gap(3);
    ctrl_enable = 1'b0;
    @(negedge Clk);
    check("t6_busy", busy, 0);
    check("t6_rx_en", Rx_EN, 0);
    check("t6_error", msg_error, 0);
    send_byte(8'h99, 1, 0, 0);
    check("t6_busy_disabled", busy, 0);
    check("t6_data_kept", msg_data, exp_msg);
    ctrl_enable = 1'b1;
    gap(2);
    check("t6_rx_en_back", Rx_EN, 1);
    check("t6_no_pulse", n_pulses, 0);
    lb = last_of(8'hC0, 8'hFF, 8'hEE, 8'h12);
    exp_msg = {8'hC0, 8'hFF, 8'hEE, lb};
    send_byte(8'hC0, 1, 0, 0); gap(3);
    send_byte(8'hFF, 1, 0, 0); gap(3);
    send_byte(8'hEE, 1, 0, 0); gap(3);
    send_byte(lb, 1, 0, 0);
    check("t6_valid", msg_valid, 1);
    check("t6_data", msg_data, exp_msg);
    gap(2);

`ifdef UART_MSG_CHECKSUM_EN
    send_byte(8'h10, 1, 0, 0); gap(3);
    send_byte(8'h20, 1, 0, 0); gap(3);
    send_byte(8'h30, 1, 0, 0); gap(3);
    send_byte(8'h31, 1, 0, 0);
    check("ck_code", err_code, 3'b100);
    check("ck_data_kept", msg_data, exp_msg);
    gap(2);
`endif

    // asynchronous reset mid-message
    send_byte(8'h66, 1, 0, 0);
    check("ar_busy_before", busy, 1);
    #5 reset = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_rx_en", Rx_EN, 0);
    check("ar_data", msg_data, 0);
    check("ar_baud", baud_select, 3'b000);
    gap(2);
    reset = 1'b1;
    gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
